// File: rtl/line_ctrl_pkg.sv
// Shared types and constants for the line buffer controller.
// Latency: n/a. Backpressure: n/a.
package line_ctrl_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 8;
  localparam int ROW_W        = 3 * PIX_W;
  localparam int NUM_BUF      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  typedef logic [1:0] buf_idx_t;

  typedef struct packed {
    logic [ROW_W-1:0] row2;
    logic [ROW_W-1:0] row1;
    logic [ROW_W-1:0] row0;
  } window_t;

  function automatic logic [NUM_BUF-1:0] buf_onehot(input buf_idx_t idx);
    buf_onehot = NUM_BUF'(1) << idx;
  endfunction

  // The three buffers read together, starting at the oldest line, wrapping mod 4.
  function automatic logic [NUM_BUF-1:0] read_mask(input buf_idx_t idx);
    buf_idx_t idx1;
    buf_idx_t idx2;
    idx1 = idx + 2'd1;
    idx2 = idx + 2'd2;
    read_mask = buf_onehot(idx) | buf_onehot(idx1) | buf_onehot(idx2);
  endfunction

endpackage

// File: rtl/line_row_mux.sv
// Rotating 4->3 row select: picks the three line buffers starting at rd_sel.
// Latency: combinational. Backpressure: none.
module line_row_mux
  import line_ctrl_pkg::*;
(
  input  logic [NUM_BUF*ROW_W-1:0] lb_pixels,
  input  buf_idx_t                 rd_sel,
  output window_t                  window
);

  buf_idx_t sel1;
  buf_idx_t sel2;

  assign sel1 = rd_sel + 2'd1;
  assign sel2 = rd_sel + 2'd2;

  assign window.row0 = lb_pixels[rd_sel*ROW_W +: ROW_W];
  assign window.row1 = lb_pixels[sel1*ROW_W +: ROW_W];
  assign window.row2 = lb_pixels[sel2*ROW_W +: ROW_W];

endmodule

// File: rtl/line_buffer_ctrl.sv
// Steers input words into four line buffers and reads three lines out as 3x3 window columns.
// Latency: write strobe and window mux are combinational; read pass starts the cycle after the third line lands.
// Backpressure: o_ready drops while all four buffers hold unread lines. Optional LINE_CTRL_STALL_CNT_EN adds a stall counter.
module line_buffer_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 324
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_pixel_valid,
  output logic                     o_ready,
  output logic [NUM_BUF-1:0]       o_lb_pixel_valid,
  output logic [NUM_BUF-1:0]       o_lb_read,
  input  logic [NUM_BUF*ROW_W-1:0] i_lb_pixels,
  output logic [3*ROW_W-1:0]       o_window,
  output logic                     o_window_valid,
  output logic                     o_intr,
  output logic [15:0]              o_stall_count
);

  localparam int         WORDS_PER_LINE = IMAGE_WIDTH / (DATA_WIDTH / PIX_W);
  localparam logic [10:0] LAST_WORD     = 11'(WORDS_PER_LINE - 1);
  localparam logic [10:0] LAST_COL      = 11'(IMAGE_WIDTH - 1);

  state_t             state;
  buf_idx_t           wr_sel;
  buf_idx_t           rd_sel;
  logic [10:0]        word_cnt;
  logic [10:0]        col_cnt;
  logic [2:0]         lines_full;
  logic [2:0]         lines_full_nxt;
  logic               win_vld_q;
  logic [NUM_BUF-1:0] rd_mask_q;
  logic               intr_q;
  logic               accept;
  logic               line_done;
  logic               pass_done;
  window_t            window;

  assign o_ready   = (lines_full < 3'd4);
  assign accept    = i_pixel_valid && o_ready;
  assign line_done = accept && (word_cnt == LAST_WORD);
  assign pass_done = (state == READ) && (col_cnt == LAST_COL);

  // A line completing in the same cycle a pass retires leaves the count unchanged.
  always_comb begin
    lines_full_nxt = lines_full;
    case ({line_done, pass_done})
      2'b10:   lines_full_nxt = lines_full + 3'd1;
      2'b01:   lines_full_nxt = lines_full - 3'd1;
      default: lines_full_nxt = lines_full;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      wr_sel     <= '0;
      rd_sel     <= '0;
      word_cnt   <= '0;
      col_cnt    <= '0;
      lines_full <= '0;
      win_vld_q  <= 1'b0;
      rd_mask_q  <= '0;
      intr_q     <= 1'b0;
    end else begin
      lines_full <= lines_full_nxt;
      intr_q     <= pass_done;

      if (accept) begin
        if (line_done) begin
          word_cnt <= '0;
          wr_sel   <= wr_sel + 2'd1;
        end else begin
          word_cnt <= word_cnt + 11'd1;
        end
      end

      // Entry looks at the updated count so the pass begins right after the third line lands.
      case (state)
        IDLE: begin
          col_cnt <= '0;
          if (lines_full_nxt >= 3'd3) begin
            state     <= READ;
            win_vld_q <= 1'b1;
            rd_mask_q <= read_mask(rd_sel);
          end
        end
        READ: begin
          if (pass_done) begin
            state     <= IDLE;
            col_cnt   <= '0;
            rd_sel    <= rd_sel + 2'd1;
            win_vld_q <= 1'b0;
            rd_mask_q <= '0;
          end else begin
            col_cnt <= col_cnt + 11'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_row_mux u_row_mux (
    .lb_pixels (i_lb_pixels),
    .rd_sel    (rd_sel),
    .window    (window)
  );

  assign o_lb_pixel_valid = accept ? buf_onehot(wr_sel) : '0;
  assign o_lb_read        = rd_mask_q;
  assign o_window_valid   = win_vld_q;
  assign o_window         = window;
  assign o_intr           = intr_q;

`ifdef LINE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (i_pixel_valid && !o_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_count = stall_cnt;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with IMAGE_WIDTH = 324 (81 words per line).
module tb_line_buffer_ctrl;

  localparam int WPL = 81;
  localparam int W   = 324;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pixel_valid = 1'b0;
  logic [95:0] i_lb_pixels = '0;
  logic        o_ready;
  logic [3:0]  o_lb_pixel_valid;
  logic [3:0]  o_lb_read;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        o_intr;
  logic [15:0] o_stall_count;

  line_buffer_ctrl #(.DATA_WIDTH(32), .IMAGE_WIDTH(W)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_pixel_valid    (i_pixel_valid),
    .o_ready          (o_ready),
    .o_lb_pixel_valid (o_lb_pixel_valid),
    .o_lb_read        (o_lb_read),
    .i_lb_pixels      (i_lb_pixels),
    .o_window         (o_window),
    .o_window_valid   (o_window_valid),
    .o_intr           (o_intr),
    .o_stall_count    (o_stall_count)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_model = 1'b1;

  // Reference model: counts of words, completed lines and completed passes.
  int m_words, m_lines, m_passes, m_left, m_stall;
  bit m_intr;

  function automatic logic [3:0] rd_mask(input int b);
    int v;
    v = (1 << (b % 4)) | (1 << ((b + 1) % 4)) | (1 << ((b + 2) % 4));
    return v[3:0];
  endfunction

  function automatic logic [71:0] exp_win(input logic [95:0] px, input int b);
    logic [23:0] r0, r1, r2;
    r0 = px[((b    ) % 4)*24 +: 24];
    r1 = px[((b + 1) % 4)*24 +: 24];
    r2 = px[((b + 2) % 4)*24 +: 24];
    return {r2, r1, r0};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic r);
    int   stored;
    logic rdy, acc, was_reading;
    @(posedge i_clock);
    #1;
    i_pixel_valid = v;
    i_reset       = r;
    i_lb_pixels   = {$urandom(), $urandom(), $urandom()};
    #4;
    if (r) begin
      m_words = 0; m_lines = 0; m_passes = 0; m_left = 0; m_stall = 0; m_intr = 0;
      cyc = 0;
    end else begin
      stored = m_lines - m_passes;
      rdy    = (stored < 4);
      acc    = v && rdy;
      if (chk_model) begin
        chk("ready", o_ready, rdy);
        chk("lb_pixel_valid", o_lb_pixel_valid, acc ? 4'(1 << (m_lines % 4)) : 4'b0);
        chk("window_valid", o_window_valid, m_left > 0);
        chk("lb_read", o_lb_read, (m_left > 0) ? rd_mask(m_passes) : 4'b0);
        if (m_left > 0) chk("window", o_window, exp_win(i_lb_pixels, m_passes));
        chk("intr", o_intr, m_intr);
`ifdef LINE_CTRL_STALL_CNT_EN
        chk("stall_count", o_stall_count, 16'(m_stall));
`else
        chk("stall_count", o_stall_count, 16'd0);
`endif
      end
      if (v && !rdy && m_stall < 65535) m_stall++;
      was_reading = (m_left > 0);
      m_intr = 0;
      if (acc) begin
        m_words++;
        if (m_words == WPL) begin
          m_words = 0;
          m_lines++;
        end
      end
      if (was_reading) begin
        m_left--;
        if (m_left == 0) begin
          m_passes++;
          m_intr = 1;
        end
      end else if (m_lines - m_passes >= 3) begin
        m_left = W;
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  typedef struct {
    int         n;
    logic       v;
    logic       rdy;
    logic [3:0] pv;
    logic [3:0] rd;
    logic       wv;
    logic       intr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int stalls, n_end, k;
    logic prev_wv;

    tbl[0] = '{1,   1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{WPL, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0};
    tbl[2] = '{WPL, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{WPL, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0};
    tbl[4] = '{W,   1'b0, 1'b1, 4'b0000, 4'b0111, 1'b1, 1'b0};
    tbl[5] = '{1,   1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[6] = '{5,   1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};

    // Three lines then one full pass, checked against the table.
    chk_model = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step(tbl[i].v, 1'b0);
        chk("t1_ready", o_ready, tbl[i].rdy);
        chk("t1_pixel_valid", o_lb_pixel_valid, tbl[i].pv);
        chk("t1_lb_read", o_lb_read, tbl[i].rd);
        chk("t1_window_valid", o_window_valid, tbl[i].wv);
        chk("t1_intr", o_intr, tbl[i].intr);
        if (tbl[i].wv) chk("t1_window", o_window, exp_win(i_lb_pixels, 0));
      end
    end
    chk_model = 1'b1;

    // Continuous input: stall while four lines are held, second pass rotated by one.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 700; i++) begin
      step(1'b1, 1'b0);
      if (i <= 600 && !o_ready) stalls++;
      if (i == 567) chk("t2_ready_resume", o_ready, 1'b1);
      if (i == 568) begin
        chk("t2_pass2_read", o_lb_read, 4'b1110);
        chk("t2_pass2_window", o_window, {i_lb_pixels[95:72], i_lb_pixels[71:48], i_lb_pixels[47:24]});
      end
    end
    chk("t2_stall_cycles", stalls, 243);

    // Fourth line completes on the last cycle of the first pass.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step((i < 243) || (i >= 486 && i <= 567), 1'b0);
      if (i == 566) chk("t3_last_write", o_lb_pixel_valid, 4'b1000);
      if (i == 567) begin
        chk("t3_wr_wrap", o_lb_pixel_valid, 4'b0001);
        chk("t3_ready", o_ready, 1'b1);
        chk("t3_intr", o_intr, 1'b1);
      end
      if (i == 568) chk("t3_next_pass", o_lb_read, 4'b1110);
    end

    // Reset in the middle of a pass (column 100).
    do_reset();
    for (int i = 0; i < 343; i++) step(i < 243, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("t4_window_valid", o_window_valid, 1'b0);
    chk("t4_ready", o_ready, 1'b1);
    chk("t4_lb_read", o_lb_read, 4'b0000);
    chk("t4_refill_buf0", o_lb_pixel_valid, 4'b0001);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

    // Ten stalled cycles with valid held high.
    do_reset();
    for (int i = 0; i < 4 * WPL; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk("t5_stalled", o_ready, 1'b0);
    end
    step(1'b0, 1'b0);
`ifdef LINE_CTRL_STALL_CNT_EN
    chk("t5_stall_count", o_stall_count, 16'd10);
`else
    chk("t5_stall_count", o_stall_count, 16'd0);
`endif

    // Random valid until six passes complete; each pass must rotate the read base.
    do_reset();
    n_end = 0;
    k = 0;
    prev_wv = 1'b0;
    for (int i = 0; i < 6000 && n_end < 6; i++) begin
      step(($urandom % 10) < 7, 1'b0);
      if (o_window_valid && !prev_wv) begin
        chk("t6_pass_base", o_lb_read, rd_mask(k));
        k++;
      end
      prev_wv = o_window_valid;
      if (o_intr) n_end++;
    end
    chk("t6_passes_done", n_end, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
